// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: FSM state encodings,
// config register addresses and fixed bit positions.
package irq_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_SERVICE = 2'd1,
    IRQ_HOLDOFF = 2'd2
  } irq_state_e;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_CAUSE   = 2'd2;

  localparam int GIE_BIT         = 31;
  localparam int CAUSE_VALID_BIT = 31;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder; index 0 has the highest priority.
module irq_prio_enc #(
  parameter int N_SRC = 4,
  parameter int IDX_W = 3
) (
  input  logic [N_SRC-1:0] req,
  output logic [IDX_W-1:0] sel,
  output logic             any
);

  // Scanning downwards lets the lowest set index be the last (winning) write.
  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        sel = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-latched pending sources, masked and prioritised,
// issuing one-cycle take pulses to the CPU decoder while in user mode.
module irq_ctrl #(
  parameter int N_SRC = 4,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src_irq,
  input  logic             kernel,
  input  logic             eret,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata,
  output logic             irq,
  output logic             in_service
);

  import irq_pkg::*;

  irq_state_e       state, state_d;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] pending, pending_d;
  logic [N_SRC-1:0] en_mask;
  logic             gie;
  logic             cause_valid;
  logic [IDX_W-1:0] cause_idx;

  logic [N_SRC-1:0] rise, eligible, pend_clr, take_clr;
  logic [IDX_W-1:0] sel;
  logic             any;
  logic             take;
  logic             unused_wdata;

  assign unused_wdata = ^cfg_wdata[30:N_SRC];

  irq_prio_enc #(.N_SRC(N_SRC), .IDX_W(IDX_W)) u_prio (
    .req (eligible),
    .sel (sel),
    .any (any)
  );

  assign rise       = src_irq & ~src_q;
  assign eligible   = pending & en_mask;
  assign take       = (state == IRQ_IDLE) && any && gie && !kernel;
  assign irq        = take;
  assign in_service = (state == IRQ_SERVICE);

  // A fresh rising edge wins over both the W1C and the take-clear of the same bit.
  always_comb begin
    pend_clr  = (cfg_we && cfg_addr == ADDR_PENDING) ? cfg_wdata[N_SRC-1:0] : '0;
    take_clr  = take ? (N_SRC'(1) << sel) : '0;
    pending_d = (pending & ~pend_clr & ~take_clr) | rise;
  end

  always_comb begin
    state_d = state;
    case (state)
      IRQ_IDLE:    if (take) state_d = IRQ_SERVICE;
      IRQ_SERVICE: if (eret) state_d = IRQ_HOLDOFF;
      IRQ_HOLDOFF: state_d = IRQ_IDLE;
      default:     state_d = IRQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IRQ_IDLE;
      src_q       <= '0;
      pending     <= '0;
      en_mask     <= '0;
      gie         <= 1'b0;
      cause_valid <= 1'b0;
      cause_idx   <= '0;
    end else begin
      state   <= state_d;
      src_q   <= src_irq;
      pending <= pending_d;
      if (cfg_we && cfg_addr == ADDR_ENABLE) begin
        en_mask <= cfg_wdata[N_SRC-1:0];
        gie     <= cfg_wdata[GIE_BIT];
      end
      if (take) begin
        cause_valid <= 1'b1;
        cause_idx   <= sel;
      end
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_ENABLE: begin
        cfg_rdata[GIE_BIT]     = gie;
        cfg_rdata[N_SRC-1:0]   = en_mask;
      end
      ADDR_PENDING: cfg_rdata[N_SRC-1:0] = pending;
      ADDR_CAUSE: begin
        cfg_rdata[CAUSE_VALID_BIT] = cause_valid;
        cfg_rdata[IDX_W-1:0]       = cause_idx;
      end
      default: cfg_rdata = '0;
    endcase
  end

endmodule
